// File: rtl/fifo_lvl_pkg.sv
// Shared definitions for the level-tracking UART FIFO: read-mode constants and
// the helper that sizes the occupancy counter.
package fifo_lvl_pkg;

    localparam bit ModeFwft = 1'b1;
    localparam bit ModeReg  = 1'b0;

    // Occupancy runs 0..size inclusive, so it needs one more code than size.
    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/fifo_lvl_ram.sv
// FIFO storage: WORD x SIZE array, synchronous write, asynchronous read.
module fifo_lvl_ram #(
    parameter int unsigned WORD  = 8,
    parameter int unsigned SIZE  = 16,
    parameter int unsigned ADDRW = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] waddr_i,
    input  logic [WORD-1:0]  wdata_i,
    input  logic [ADDRW-1:0] raddr_i,
    output logic [WORD-1:0]  rdata_o
);

    logic [WORD-1:0] mem [SIZE];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO of arbitrary depth with occupancy count, threshold flags,
// sticky error flags, flush, and selectable FWFT or registered read.
module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int unsigned WORD     = 8,
    parameter int unsigned SIZE     = 16,
    parameter int unsigned AF_LEVEL = SIZE - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = ModeFwft
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       wr_i,
    input  logic [WORD-1:0]            wr_data_i,
    input  logic                       rd_i,
    output logic [WORD-1:0]            rd_data_o,
    output logic                       rd_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [cnt_width(SIZE)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned CntW = cnt_width(SIZE);
    localparam int unsigned PtrW = $clog2(SIZE);

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            af_q, af_d, ae_q, ae_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            rd_acc, wr_acc;
    logic [WORD-1:0] ram_rdata;

    assign rd_acc = rd_i & ~empty_q;
    // A write into a full FIFO fits only because the same-cycle read frees a slot.
    assign wr_acc = wr_i & (~full_q | rd_acc);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(SIZE - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        full_d  = (count_d == CntW'(SIZE));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CntW'(AF_LEVEL));
        ae_d    = (count_d <= CntW'(AE_LEVEL));
        ovf_d   = ovf_q | (wr_i & ~wr_acc);
        unf_d   = unf_q | (rd_i & ~rd_acc);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= (AF_LEVEL == 0);
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Read-before-write: the async read sees the old word at the shared address.
    fifo_lvl_ram #(
        .WORD (WORD),
        .SIZE (SIZE),
        .ADDRW(PtrW)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_data_i),
        .raddr_i(rd_ptr_q),
        .rdata_o(ram_rdata)
    );

    if (FWFT == ModeFwft) begin : g_fwft
        assign rd_data_o  = ram_rdata;
        assign rd_valid_o = ~empty_q;
    end else begin : g_reg
        logic [WORD-1:0] rdata_q;
        logic            rvalid_q;

        always_ff @(posedge clk_i) begin
            if (rst_i || clr_i) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= ram_rdata;
                end
            end
        end

        assign rd_data_o  = rdata_q;
        assign rd_valid_o = rvalid_q;
    end

    assign count_o        = count_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed bench: a 16-deep FWFT FIFO, a 5-deep FWFT FIFO and a 16-deep
// registered-read FIFO, each exercised by its own scenario tasks.
module tb_fifo_lvl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;

    // 16-deep, FWFT
    logic       a_rst, a_clr, a_wr, a_rd;
    logic [7:0] a_wd, a_rdat;
    logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_cnt;

    // 5-deep, FWFT
    logic       b_rst, b_clr, b_wr, b_rd;
    logic [7:0] b_wd, b_rdat;
    logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_cnt;

    // 16-deep, registered read
    logic       c_rst, c_clr, c_wr, c_rd;
    logic [7:0] c_wd, c_rdat;
    logic       c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [4:0] c_cnt;

    fifo_lvl #(.WORD(8), .SIZE(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_a (
        .clk_i(clk), .rst_i(a_rst), .clr_i(a_clr), .wr_i(a_wr), .wr_data_i(a_wd),
        .rd_i(a_rd), .rd_data_o(a_rdat), .rd_valid_o(a_rv), .full_o(a_full),
        .empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .count_o(a_cnt), .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    fifo_lvl #(.WORD(8), .SIZE(5), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_b (
        .clk_i(clk), .rst_i(b_rst), .clr_i(b_clr), .wr_i(b_wr), .wr_data_i(b_wd),
        .rd_i(b_rd), .rd_data_o(b_rdat), .rd_valid_o(b_rv), .full_o(b_full),
        .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .count_o(b_cnt), .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    fifo_lvl #(.WORD(8), .SIZE(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_c (
        .clk_i(clk), .rst_i(c_rst), .clr_i(c_clr), .wr_i(c_wr), .wr_data_i(c_wd),
        .rd_i(c_rd), .rd_data_o(c_rdat), .rd_valid_o(c_rv), .full_o(c_full),
        .empty_o(c_empty), .almost_full_o(c_af), .almost_empty_o(c_ae),
        .count_o(c_cnt), .overflow_o(c_ovf), .underflow_o(c_unf)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_rst = 0; a_clr = 0; a_wr = 0; a_rd = 0; a_wd = 8'h00;
    endtask

    task automatic test_reset();
        a_idle(); a_rst = 1;
        b_rst = 1; b_clr = 0; b_wr = 0; b_rd = 0; b_wd = 8'h00;
        c_rst = 1; c_clr = 0; c_wr = 0; c_rd = 0; c_wd = 8'h00;
        tick();
        a_rst = 0; b_rst = 0; c_rst = 0;
        chks++;
        if (a_cnt !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_ae !== 1'b1
            || a_af !== 1'b0 || a_ovf !== 1'b0 || a_unf !== 1'b0 || a_rv !== 1'b0) begin
            errs++;
            $display("FAIL reset_a: cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b rv=%b want 0 1 0 1 0 0 0 0",
                     a_cnt, a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_rv);
        end
        chks++;
        if (b_cnt !== 3'd0 || b_empty !== 1'b1 || b_full !== 1'b0 || b_ae !== 1'b1
            || b_af !== 1'b0) begin
            errs++;
            $display("FAIL reset_b: cnt=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
                     b_cnt, b_empty, b_full, b_ae, b_af);
        end
        chks++;
        if (c_cnt !== 5'd0 || c_empty !== 1'b1 || c_rv !== 1'b0 || c_rdat !== 8'h00
            || c_ovf !== 1'b0 || c_unf !== 1'b0) begin
            errs++;
            $display("FAIL reset_c: cnt=%0d e=%b rv=%b rd=%h ov=%b un=%b want 0 1 0 00 0 0",
                     c_cnt, c_empty, c_rv, c_rdat, c_ovf, c_unf);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_wd = 8'(i);
            tick();
            chks++;
            if (a_cnt !== 5'(i + 1) || a_af !== (i + 1 >= 14) || a_full !== (i + 1 == 16)) begin
                errs++;
                $display("FAIL fill[%0d]: cnt=%0d af=%b full=%b want %0d %b %b", i, a_cnt, a_af,
                         a_full, i + 1, (i + 1 >= 14), (i + 1 == 16));
            end
        end
        a_wr = 0;
        for (int i = 0; i < 16; i++) begin
            chks++;
            if (a_rdat !== 8'(i) || a_rv !== 1'b1) begin
                errs++;
                $display("FAIL drain_data[%0d]: got %h rv=%b want %h rv=1", i, a_rdat, a_rv, 8'(i));
            end
            a_rd = 1;
            tick();
            chks++;
            if (a_cnt !== 5'(15 - i) || a_ae !== (15 - i <= 2) || a_empty !== (i == 15)) begin
                errs++;
                $display("FAIL drain[%0d]: cnt=%0d ae=%b empty=%b want %0d %b %b", i, a_cnt, a_ae,
                         a_empty, 15 - i, (15 - i <= 2), (i == 15));
            end
        end
        a_rd = 0;
        chks++;
        if (a_ovf !== 1'b0 || a_unf !== 1'b0 || a_rv !== 1'b0) begin
            errs++;
            $display("FAIL drain_flags: ov=%b un=%b rv=%b want 0 0 0", a_ovf, a_unf, a_rv);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_wd = 8'h10 + 8'(i);
            tick();
        end
        a_wr = 1; a_rd = 1; a_wd = 8'h99;
        tick();
        a_wr = 0; a_rd = 0;
        chks++;
        if (a_cnt !== 5'd16 || a_full !== 1'b1 || a_ovf !== 1'b0 || a_rdat !== 8'h11) begin
            errs++;
            $display("FAIL full_wr_rd: cnt=%0d full=%b ov=%b head=%h want 16 1 0 11",
                     a_cnt, a_full, a_ovf, a_rdat);
        end
        for (int i = 0; i < 16; i++) begin
            chks++;
            if (a_rdat !== ((i == 15) ? 8'h99 : 8'h11 + 8'(i))) begin
                errs++;
                $display("FAIL wrap_order[%0d]: got %h want %h", i, a_rdat,
                         (i == 15) ? 8'h99 : 8'h11 + 8'(i));
            end
            a_rd = 1;
            tick();
        end
        a_rd = 0;
        a_wr = 1; a_rd = 1; a_wd = 8'h42;
        tick();
        a_wr = 0; a_rd = 0;
        chks++;
        if (a_cnt !== 5'd1 || a_unf !== 1'b1 || a_rdat !== 8'h42 || a_ovf !== 1'b0) begin
            errs++;
            $display("FAIL empty_wr_rd: cnt=%0d un=%b data=%h ov=%b want 1 1 42 0",
                     a_cnt, a_unf, a_rdat, a_ovf);
        end
        a_clr = 1;
        tick();
        a_clr = 0;
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_wd = 8'h20 + 8'(i);
            tick();
        end
        a_wd = 8'hEE;
        tick();
        a_wr = 0;
        chks++;
        if (a_ovf !== 1'b1 || a_cnt !== 5'd16 || a_rdat !== 8'h20) begin
            errs++;
            $display("FAIL overflow_set: ov=%b cnt=%0d head=%h want 1 16 20", a_ovf, a_cnt, a_rdat);
        end
        repeat (10) tick();
        chks++;
        if (a_ovf !== 1'b1 || a_cnt !== 5'd16) begin
            errs++;
            $display("FAIL overflow_sticky: ov=%b cnt=%0d want 1 16", a_ovf, a_cnt);
        end
        a_clr = 1;
        tick();
        a_clr = 0;
        chks++;
        if (a_cnt !== 5'd0 || a_empty !== 1'b1 || a_ovf !== 1'b0 || a_full !== 1'b0
            || a_af !== 1'b0 || a_ae !== 1'b1) begin
            errs++;
            $display("FAIL clr: cnt=%0d e=%b ov=%b f=%b af=%b ae=%b want 0 1 0 0 0 1",
                     a_cnt, a_empty, a_ovf, a_full, a_af, a_ae);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_rd = (i == 4); a_wd = 8'h60 + 8'(i);
            tick();
        end
        a_rst = 1; a_wr = 1; a_rd = 1;
        tick();
        a_rst = 0; a_wr = 0; a_rd = 0;
        chks++;
        if (a_cnt !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_af !== 1'b0
            || a_ae !== 1'b1 || a_ovf !== 1'b0 || a_unf !== 1'b0 || a_rv !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid: cnt=%0d e=%b f=%b af=%b ae=%b ov=%b un=%b rv=%b",
                     a_cnt, a_empty, a_full, a_af, a_ae, a_ovf, a_unf, a_rv);
        end
    endtask

    task automatic test_non_pow2();
        for (int i = 0; i < 5; i++) begin
            b_wr = 1; b_wd = 8'h50 + 8'(i);
            tick();
        end
        b_wr = 0;
        chks++;
        if (b_cnt !== 3'd5 || b_full !== 1'b1 || b_af !== 1'b1) begin
            errs++;
            $display("FAIL np2_fill: cnt=%0d full=%b af=%b want 5 1 1", b_cnt, b_full, b_af);
        end
        for (int i = 0; i < 3; i++) begin
            chks++;
            if (b_rdat !== 8'h50 + 8'(i)) begin
                errs++;
                $display("FAIL np2_read[%0d]: got %h want %h", i, b_rdat, 8'h50 + 8'(i));
            end
            b_rd = 1;
            tick();
        end
        b_rd = 0;
        for (int i = 0; i < 3; i++) begin
            b_wr = 1; b_wd = 8'h55 + 8'(i);
            tick();
        end
        b_wr = 0;
        chks++;
        if (b_cnt !== 3'd5 || b_full !== 1'b1 || b_ovf !== 1'b0) begin
            errs++;
            $display("FAIL np2_refill: cnt=%0d full=%b ov=%b want 5 1 0", b_cnt, b_full, b_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            chks++;
            if (b_rdat !== 8'h53 + 8'(i)) begin
                errs++;
                $display("FAIL np2_wrap[%0d]: got %h want %h", i, b_rdat, 8'h53 + 8'(i));
            end
            b_rd = 1;
            tick();
        end
        b_rd = 0;
        chks++;
        if (b_empty !== 1'b1 || b_unf !== 1'b0) begin
            errs++;
            $display("FAIL np2_empty: empty=%b un=%b want 1 0", b_empty, b_unf);
        end
    endtask

    task automatic test_registered();
        c_wr = 1; c_wd = 8'hA5;
        tick();
        c_wr = 0;
        chks++;
        if (c_rv !== 1'b0 || c_cnt !== 5'd1) begin
            errs++;
            $display("FAIL reg_nofall: rv=%b cnt=%0d want 0 1", c_rv, c_cnt);
        end
        c_rd = 1;
        tick();
        c_rd = 0;
        chks++;
        if (c_rv !== 1'b1 || c_rdat !== 8'hA5 || c_empty !== 1'b1) begin
            errs++;
            $display("FAIL reg_read: rv=%b data=%h empty=%b want 1 a5 1", c_rv, c_rdat, c_empty);
        end
        tick();
        chks++;
        if (c_rv !== 1'b0 || c_rdat !== 8'hA5) begin
            errs++;
            $display("FAIL reg_pulse: rv=%b data=%h want 0 a5", c_rv, c_rdat);
        end
        c_rd = 1;
        tick();
        c_rd = 0;
        chks++;
        if (c_rv !== 1'b0 || c_unf !== 1'b1 || c_rdat !== 8'hA5) begin
            errs++;
            $display("FAIL reg_underflow: rv=%b un=%b data=%h want 0 1 a5", c_rv, c_unf, c_rdat);
        end
    endtask

    task automatic test_fwft();
        a_wr = 1; a_wd = 8'h3C;
        tick();
        a_wd = 8'h3D;
        chks++;
        if (a_rv !== 1'b1 || a_rdat !== 8'h3C) begin
            errs++;
            $display("FAIL fwft_fall: rv=%b data=%h want 1 3c", a_rv, a_rdat);
        end
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        chks++;
        if (a_rv !== 1'b1 || a_rdat !== 8'h3D || a_cnt !== 5'd1) begin
            errs++;
            $display("FAIL fwft_next: rv=%b data=%h cnt=%0d want 1 3d 1", a_rv, a_rdat, a_cnt);
        end
        tick();
        a_rd = 0;
        chks++;
        if (a_empty !== 1'b1 || a_rv !== 1'b0 || a_unf !== 1'b0) begin
            errs++;
            $display("FAIL fwft_empty: empty=%b rv=%b un=%b want 1 0 0", a_empty, a_rv, a_unf);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        test_non_pow2();
        test_registered();
        test_fwft();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
Parametrised successor to the UART TX/RX FIFO. Synchronous FIFO of any depth, not only powers of two, with an occupancy count, programmable almost-full and almost-empty thresholds, and a synchronous flush. It also provides sticky overflow/underflow error flags and a selectable read mode: first-word-fall-through or registered read with a valid strobe. It sits between the UART baud-rate TX/RX engines and the bus-side register interface, and can replace the existing FIFO in both directions.

Parameters:
WORD, 8, data width in bits.
SIZE, 16, number of entries; any value >= 2.
AF_LEVEL, SIZE-2, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.
FWFT, 1, 1 = first-word-fall-through read; 0 = registered read with one-cycle latency.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  reset; synchronous, active-high.
clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
wr  in  1  write request.
wr_data  in  WORD  write data.
rd  in  1  read request (FWFT=1: pop/acknowledge; FWFT=0: fetch).
rd_data  out  WORD  read data.
rd_valid  out  1  FWFT=1: equals ~empty; FWFT=0: one-cycle pulse marking rd_data valid.
full  out  1  count == SIZE.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  $clog2(SIZE+1)  current occupancy, 0..SIZE.
overflow  out  1  sticky; set by a write that is not accepted.
underflow  out  1  sticky; set by a read that is not accepted.

Behaviour:
- Reset is synchronous and active-high, on the single clock clk (already decided).
- Reset values on rst: count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0, rd_valid=0, rd_data=0, pointers=0.
- Storage is not reset; its contents are don't-care until written.
- clr has the same effect as rst on all state except storage; rst takes priority over clr.
- Read acceptance: rd_acc = rd & ~empty.
- Write acceptance: wr_acc = wr & (~full | rd_acc). A write while full is accepted only when it coincides with an accepted read.
- Write while empty with a simultaneous read: the write is accepted, the read is rejected and underflow is set.
- count_next = count + wr_acc - rd_acc. All flags are registered and derived from count_next, so they are valid in the same cycle as count.
- Pointers: wr_ptr and rd_ptr are each $clog2(SIZE) bits. Each advances by 1 on acceptance and wraps from SIZE-1 to 0 explicitly; no reliance on power-of-two overflow.
- Errors: overflow is set on wr & ~wr_acc; underflow is set on rd & ~rd_acc. Both hold until rst or clr.
- FWFT=1: rd_data = mem[rd_ptr] combinationally. It is valid whenever ~empty and is don't-care when empty. A write into an empty FIFO is visible on rd_data in the cycle after the write edge.
- FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] at the same edge and rd_valid pulses high for one cycle. Otherwise rd_data holds its value and rd_valid=0.
- A rejected read (rd while empty) in FWFT=0 produces no rd_valid pulse.
- An accepted read and write to the same address in the same cycle (count==SIZE wrap case) return the old data; the write lands after the read.

Decomposition:
- Shared header uart_fifo_defs: FWFT/registered mode constants and the function computing the count width.
- One sub-module, fifo_ram: WORD x SIZE array with synchronous write and asynchronous read. It is instantiated once.
- Pointer, count, flag and read-mode logic stays in fifo_lvl.

Test Plan:
- Fill/drain: SIZE=16, AF_LEVEL=14, AE_LEVEL=2. Write 0x00..0x0F on consecutive cycles, then read 16.
  - Writing: count goes 1..16; almost_full rises when count=14; full=1 after the 16th write.
  - Reading: data comes out 0x00..0x0F in order; almost_empty rises when count=2; empty=1 at the end; no error flags set.
- Non-power-of-two: SIZE=5. Write 5, read 3, write 3.
  - Pointers wrap 4->0; count=5 and full=1.
  - Reading 5 returns the writes in order.
- Simultaneous access:
  - Full (count=16) with wr=rd=1: count stays 16, the head word pops, the new word is appended, overflow stays 0.
  - Empty with wr=rd=1: count becomes 1, underflow=1.
- Errors and flush:
  - When full, wr=1 with rd=0 sets overflow=1; the data is unchanged; overflow stays 1 across 10 idle cycles.
  - clr=1 for one cycle: count=0, empty=1, overflow=0.
  - rst asserted mid-burst: all outputs take their reset values at the next edge.
- FWFT=0 timing: write 0xA5, then pulse rd.
  - rd_data=0xA5 and rd_valid=1 exactly one cycle after rd; rd_valid=0 the following cycle.
  - rd while empty gives no rd_valid and sets underflow=1.
- FWFT=1 timing: write 0x3C into an empty FIFO.
  - In the next cycle rd_valid=1 and rd_data=0x3C without rd.
  - After rd, rd_data shows the next entry or empty=1.
